// File: rtl/ws_pkg.sv
// Shared types and widths for the weight-stationary filter scheduler.
package ws_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int P_MAX_DEFAULT  = 14;
  localparam int SHAPE_W        = 9;
  localparam int DIM_W          = 4;
  localparam int K_W            = 17;
  localparam int BASE_W         = 26;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE,
    ERR
  } state_t;

  // Clamp a remaining-element count to the per-tile capacity.
  function automatic logic [DIM_W-1:0] min_cnt(input logic [K_W-1:0] rem,
                                                input logic [DIM_W-1:0] cap);
    return (rem > K_W'(cap)) ? cap : rem[DIM_W-1:0];
  endfunction

endpackage

// File: rtl/tile_walker.sv
// Tile walker: p/q/tile/group counters, running-base address generator and
// partial-tile counts for the filter scheduler.
module tile_walker
  import ws_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SHAPE_W-1:0] m_in,
  input  logic [SHAPE_W-1:0] c_in,
  input  logic [DIM_W-1:0]   r_in,
  input  logic [DIM_W-1:0]   s_in,
  input  logic [DIM_W-1:0]   p_in,
  input  logic [DIM_W-1:0]   q_in,
  input  logic               fire,
  input  logic               next_tile,
  output logic               tile_end,
  output logic               layer_last,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DIM_W-1:0]   rd_p,
  output logic [DIM_W-1:0]   rd_q,
  output logic [DIM_W-1:0]   tile_p_cnt,
  output logic [DIM_W-1:0]   tile_q_cnt
);

  logic [SHAPE_W-1:0] m_r;
  logic [K_W-1:0]     k_r;
  logic [DIM_W-1:0]   p_r, q_r;
  logic [K_W-1:0]     k_shape;

  logic [SHAPE_W:0]   m_base, m_base_nxt, rem_m;
  logic [K_W-1:0]     k_base, k_base_nxt, rem_k;
  logic [DIM_W-1:0]   p_idx, p_idx_nxt, q_idx, q_idx_nxt;
  logic [BASE_W-1:0]  grp_base, grp_nxt, row_base, row_nxt, addr_full;
  logic [ADDR_W-1:0]  addr_r;

  assign k_shape = K_W'(c_in) * K_W'(r_in) * K_W'(s_in);

  assign rem_m      = ({1'b0, m_r} > m_base) ? ({1'b0, m_r} - m_base) : '0;
  assign rem_k      = (k_r > k_base) ? (k_r - k_base) : '0;
  assign tile_p_cnt = min_cnt(K_W'(rem_m), p_r);
  assign tile_q_cnt = min_cnt(rem_k, q_r);

  assign tile_end   = (({1'b0, p_idx} + 5'd1) >= {1'b0, tile_p_cnt}) &&
                      (({1'b0, q_idx} + 5'd1) >= {1'b0, tile_q_cnt});
  assign layer_last = ((k_base + K_W'(q_r)) >= k_r) &&
                      ((m_base + (SHAPE_W+1)'(p_r)) >= {1'b0, m_r});

  // row_base tracks (m_base + p) * K; at a tile end it is deliberately left on
  // the last row so the next group's base is simply one more K beyond it.
  always_comb begin
    m_base_nxt = m_base;
    k_base_nxt = k_base;
    p_idx_nxt  = p_idx;
    q_idx_nxt  = q_idx;
    grp_nxt    = grp_base;
    row_nxt    = row_base;
    if (load) begin
      m_base_nxt = '0;
      k_base_nxt = '0;
      p_idx_nxt  = '0;
      q_idx_nxt  = '0;
      grp_nxt    = '0;
      row_nxt    = '0;
    end else if (fire) begin
      if (({1'b0, p_idx} + 5'd1) < {1'b0, tile_p_cnt}) begin
        p_idx_nxt = p_idx + 4'd1;
        row_nxt   = row_base + BASE_W'(k_r);
      end else begin
        p_idx_nxt = '0;
        if (({1'b0, q_idx} + 5'd1) < {1'b0, tile_q_cnt}) begin
          q_idx_nxt = q_idx + 4'd1;
          row_nxt   = grp_base;
        end else begin
          q_idx_nxt = '0;
        end
      end
    end else if (next_tile) begin
      p_idx_nxt = '0;
      q_idx_nxt = '0;
      if ((k_base + K_W'(q_r)) < k_r) begin
        k_base_nxt = k_base + K_W'(q_r);
        row_nxt    = grp_base;
      end else begin
        k_base_nxt = '0;
        m_base_nxt = m_base + (SHAPE_W+1)'(p_r);
        grp_nxt    = row_base + BASE_W'(k_r);
        row_nxt    = row_base + BASE_W'(k_r);
      end
    end
  end

  assign addr_full = row_nxt + BASE_W'(k_base_nxt) + BASE_W'(q_idx_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r      <= '0;
      k_r      <= '0;
      p_r      <= '0;
      q_r      <= '0;
      m_base   <= '0;
      k_base   <= '0;
      p_idx    <= '0;
      q_idx    <= '0;
      grp_base <= '0;
      row_base <= '0;
      addr_r   <= '0;
    end else begin
      if (load) begin
        m_r <= m_in;
        k_r <= k_shape;
        p_r <= p_in;
        q_r <= q_in;
      end
      m_base   <= m_base_nxt;
      k_base   <= k_base_nxt;
      p_idx    <= p_idx_nxt;
      q_idx    <= q_idx_nxt;
      grp_base <= grp_nxt;
      row_base <= row_nxt;
      addr_r   <= addr_full[ADDR_W-1:0];
    end
  end

  assign rd_addr = addr_r;
  assign rd_p    = p_idx;
  assign rd_q    = q_idx;

endmodule

// File: rtl/filter_sched.sv
// Filter-bank tile scheduler: FSM and handshakes around tile_walker.
// Define FILTER_SCHED_PERF_EN to build the compute-wait performance counter.
module filter_sched
  import ws_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int P_MAX  = P_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SHAPE_W-1:0] M,
  input  logic [SHAPE_W-1:0] C,
  input  logic [DIM_W-1:0]   R,
  input  logic [DIM_W-1:0]   S,
  input  logic [DIM_W-1:0]   P,
  input  logic [DIM_W-1:0]   Q,
  input  logic               ld_rdy,
  input  logic               compute_done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DIM_W-1:0]   rd_p,
  output logic [DIM_W-1:0]   rd_q,
  output logic               tile_valid,
  output logic [DIM_W-1:0]   tile_p_cnt,
  output logic [DIM_W-1:0]   tile_q_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        perf_wait_cycles
);

  state_t state, state_nxt;
  logic   accept, cfg_bad, tile_end, layer_last, next_tile, err_hold;

  assign accept  = (state == IDLE) && start;
  assign cfg_bad = (M == '0) || (C == '0) || (R == '0) || (S == '0) ||
                   (P == '0) || (Q == '0) || (int'(P) > P_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_bad ? ERR : LOAD;
      LOAD:    if (rd_en && tile_end) state_nxt = COMPUTE;
      COMPUTE: if (compute_done) state_nxt = layer_last ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // err stays up after ERR until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                err_hold <= 1'b0;
    else if (accept)         err_hold <= 1'b0;
    else if (state == ERR)   err_hold <= 1'b1;
  end

  assign rd_en      = (state == LOAD) && ld_rdy;
  assign tile_valid = (state == COMPUTE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = (state == ERR) || err_hold;
  assign next_tile  = (state == COMPUTE) && compute_done && !layer_last;

  tile_walker #(
    .ADDR_W(ADDR_W)
  ) u_walker (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .m_in       (M),
    .c_in       (C),
    .r_in       (R),
    .s_in       (S),
    .p_in       (P),
    .q_in       (Q),
    .fire       (rd_en),
    .next_tile  (next_tile),
    .tile_end   (tile_end),
    .layer_last (layer_last),
    .rd_addr    (rd_addr),
    .rd_p       (rd_p),
    .rd_q       (rd_q),
    .tile_p_cnt (tile_p_cnt),
    .tile_q_cnt (tile_q_cnt)
  );

`ifdef FILTER_SCHED_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_cnt <= '0;
    else if (accept)
      perf_cnt <= '0;
    else if ((state == COMPUTE) && (perf_cnt != 16'hFFFF))
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign perf_wait_cycles = perf_cnt;
`else
  assign perf_wait_cycles = '0;
`endif

endmodule
